// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM SDRAM controller port between two masters.
// Read returns are steered back to their issuer through an in-order owner-tag FIFO.
module sdram_port_arbiter #(
    parameter int unsigned MAX_BURST   = 16,
    parameter int unsigned MAX_PENDING = 8,
    parameter int unsigned ADDR_W      = 24,
    parameter int unsigned DATA_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_writedata,
    input  logic              m0_read_n,
    input  logic              m0_write_n,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,
    output logic              m0_waitrequest,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_writedata,
    input  logic              m1_read_n,
    input  logic              m1_write_n,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,
    output logic              m1_waitrequest,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [DATA_W-1:0] sdram_writedata,
    output logic              sdram_read_n,
    output logic              sdram_write_n,
    output logic              sdram_chipselect,
    output logic [1:0]        sdram_byteenable_n,
    input  logic [DATA_W-1:0] sdram_readdata,
    input  logic              sdram_readdatavalid,
    input  logic              sdram_waitrequest
);

    localparam int unsigned PtrW   = $clog2(MAX_PENDING);
    localparam int unsigned CntW   = $clog2(MAX_PENDING) + 1;
    localparam int unsigned BurstW = $clog2(MAX_BURST + 1);
    localparam logic [CntW-1:0]   Full      = CntW'(MAX_PENDING);
    localparam logic [BurstW-1:0] BurstMax  = BurstW'(MAX_BURST);
    localparam logic [BurstW-1:0] BurstLast = BurstW'(MAX_BURST - 1);

    typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

    state_e              state_q, state_d;
    logic                last_gnt_q, last_gnt_d;
    logic [BurstW-1:0]   burst_cnt_q, burst_cnt_d;
    logic [MAX_PENDING-1:0] tag_q;
    logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]     pending_q;
    logic                rd_err_q;

    logic req0, req1;
    logic sel, cmd_read, cmd_write, read_block;
    logic accept, push, pop, head;

    assign req0 = !m0_read_n || !m0_write_n;
    assign req1 = !m1_read_n || !m1_write_n;

    assign accept = (cmd_write || (cmd_read && !read_block)) && !sdram_waitrequest;
    assign push   = accept && cmd_read;
    assign pop    = sdram_readdatavalid && (pending_q != '0);
    assign head   = tag_q[rd_ptr_q];

    assign sdram_chipselect   = 1'b1;
    assign sdram_byteenable_n = 2'b00;
    assign m0_readdata        = sdram_readdata;
    assign m1_readdata        = sdram_readdata;
    assign m0_readdatavalid   = !reset && pop && !head;
    assign m1_readdatavalid   = !reset && pop && head;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            last_gnt_q  <= 1'b1;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        burst_cnt_d = burst_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (req0 && req1) state_d = last_gnt_q ? StGnt0 : StGnt1;
                else if (req0)    state_d = StGnt0;
                else if (req1)    state_d = StGnt1;
            end
            StGnt0: begin
                if (!req0)                                        state_d = req1 ? StGnt1 : StIdle;
                else if (accept && burst_cnt_q >= BurstLast && req1) state_d = StGnt1;
            end
            StGnt1: begin
                if (!req1)                                        state_d = req0 ? StGnt0 : StIdle;
                else if (accept && burst_cnt_q >= BurstLast && req0) state_d = StGnt0;
            end
            default: state_d = StIdle;
        endcase
        // Saturate so an uncontested master keeps streaming without wrapping the count.
        if (accept && burst_cnt_q != BurstMax) burst_cnt_d = burst_cnt_q + 1'b1;
        if (state_d != state_q) burst_cnt_d = '0;
        if (state_d == StGnt0) last_gnt_d = 1'b0;
        if (state_d == StGnt1) last_gnt_d = 1'b1;
    end

    always_comb begin
        sel             = 1'b0;
        cmd_read        = 1'b0;
        cmd_write       = 1'b0;
        read_block      = 1'b0;
        sdram_addr      = '0;
        sdram_writedata = '0;
        sdram_read_n    = 1'b1;
        sdram_write_n   = 1'b1;
        m0_waitrequest  = 1'b1;
        m1_waitrequest  = 1'b1;
        // Reset masks the bus in the same cycle so nothing can be accepted mid-reset.
        if (!reset && state_q != StIdle) begin
            sel             = (state_q == StGnt1);
            cmd_write       = sel ? !m1_write_n : !m0_write_n;
            cmd_read        = !cmd_write && (sel ? !m1_read_n : !m0_read_n);
            read_block      = cmd_read && (pending_q == Full);
            sdram_addr      = sel ? m1_addr : m0_addr;
            sdram_writedata = sel ? m1_writedata : m0_writedata;
            sdram_write_n   = !cmd_write;
            sdram_read_n    = !(cmd_read && !read_block);
            if (sel) m1_waitrequest = sdram_waitrequest || read_block;
            else     m0_waitrequest = sdram_waitrequest || read_block;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            pending_q <= '0;
            rd_err_q  <= 1'b0;
        end else begin
            if (push) begin
                tag_q[wr_ptr_q] <= sel;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      pending_q <= pending_q + 1'b1;
            else if (pop && !push) pending_q <= pending_q - 1'b1;
            // A return with nothing outstanding is dropped and remembered.
            if (sdram_readdatavalid && pending_q == '0) rd_err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: grant order, burst limit, stalls, tag routing, reset.
module tb_sdram_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] m0_addr, m1_addr, sdram_addr;
    logic [15:0] m0_writedata, m1_writedata, sdram_writedata;
    logic        m0_read_n, m0_write_n, m1_read_n, m1_write_n;
    logic [15:0] m0_readdata, m1_readdata, sdram_readdata;
    logic        m0_readdatavalid, m1_readdatavalid, m0_waitrequest, m1_waitrequest;
    logic        sdram_read_n, sdram_write_n, sdram_chipselect;
    logic [1:0]  sdram_byteenable_n;
    logic        sdram_readdatavalid, sdram_waitrequest;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .MAX_BURST  (16),
        .MAX_PENDING(8),
        .ADDR_W     (24),
        .DATA_W     (16)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .m0_addr            (m0_addr),
        .m0_writedata       (m0_writedata),
        .m0_read_n          (m0_read_n),
        .m0_write_n         (m0_write_n),
        .m0_readdata        (m0_readdata),
        .m0_readdatavalid   (m0_readdatavalid),
        .m0_waitrequest     (m0_waitrequest),
        .m1_addr            (m1_addr),
        .m1_writedata       (m1_writedata),
        .m1_read_n          (m1_read_n),
        .m1_write_n         (m1_write_n),
        .m1_readdata        (m1_readdata),
        .m1_readdatavalid   (m1_readdatavalid),
        .m1_waitrequest     (m1_waitrequest),
        .sdram_addr         (sdram_addr),
        .sdram_writedata    (sdram_writedata),
        .sdram_read_n       (sdram_read_n),
        .sdram_write_n      (sdram_write_n),
        .sdram_chipselect   (sdram_chipselect),
        .sdram_byteenable_n (sdram_byteenable_n),
        .sdram_readdata     (sdram_readdata),
        .sdram_readdatavalid(sdram_readdatavalid),
        .sdram_waitrequest  (sdram_waitrequest)
    );

    task automatic idle_inputs();
        m0_addr = '0; m0_writedata = '0; m0_read_n = 1'b1; m0_write_n = 1'b1;
        m1_addr = '0; m1_writedata = '0; m1_read_n = 1'b1; m1_write_n = 1'b1;
        sdram_readdata = '0; sdram_readdatavalid = 1'b0; sdram_waitrequest = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({m0_waitrequest, m1_waitrequest, sdram_read_n, sdram_write_n} !== 4'b1111) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 1111",
                     {m0_waitrequest, m1_waitrequest, sdram_read_n, sdram_write_n});
        end
        checks++;
        if (dut.pending_q !== 4'd0) begin
            errors++; $display("FAIL reset_pending: got %0d expected 0", dut.pending_q);
        end
        checks++;
        if ({sdram_chipselect, sdram_byteenable_n, sdram_addr} !== {1'b1, 2'b00, 24'h0}) begin
            errors++; $display("FAIL reset_const: got %b %b %h", sdram_chipselect,
                               sdram_byteenable_n, sdram_addr);
        end
        @(negedge clk);
        reset = 1'b0;
        m0_write_n = 1'b0; m0_addr = 24'h10; m0_writedata = 16'hBEEF;
        #1;
        checks++;
        if ({m0_waitrequest, sdram_write_n} !== 2'b11) begin
            errors++; $display("FAIL first_cycle_idle: got %b expected 11",
                               {m0_waitrequest, sdram_write_n});
        end
        @(negedge clk); #1;
        checks++;
        if ({m0_waitrequest, sdram_write_n, sdram_addr, sdram_writedata} !==
            {1'b0, 1'b0, 24'h10, 16'hBEEF}) begin
            errors++; $display("FAIL first_grant: got wr_n=%b wait=%b addr=%h data=%h",
                               sdram_write_n, m0_waitrequest, sdram_addr, sdram_writedata);
        end
        @(negedge clk);
        m0_write_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_tie();
        do_reset();
        m0_write_n = 1'b0; m0_addr = 24'h20; m0_writedata = 16'h1111;
        m1_write_n = 1'b0; m1_addr = 24'h30; m1_writedata = 16'h2222;
        #1;
        checks++;
        if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin
            errors++; $display("FAIL tie_idle: got %b expected 11", {m0_waitrequest, m1_waitrequest});
        end
        @(negedge clk); #1;
        checks++;
        if ({m0_waitrequest, m1_waitrequest, sdram_addr} !== {2'b01, 24'h20}) begin
            errors++; $display("FAIL tie_m0_first: got %b addr %h", {m0_waitrequest, m1_waitrequest},
                               sdram_addr);
        end
        @(negedge clk);
        m0_write_n = 1'b1;
        #1;
        checks++;
        if ({m1_waitrequest, sdram_write_n} !== 2'b11) begin
            errors++; $display("FAIL tie_handover_hold: got %b expected 11",
                               {m1_waitrequest, sdram_write_n});
        end
        @(negedge clk); #1;
        checks++;
        if ({m1_waitrequest, sdram_addr, sdram_writedata} !== {1'b0, 24'h30, 16'h2222}) begin
            errors++; $display("FAIL tie_m1_next: got wait=%b addr=%h data=%h", m1_waitrequest,
                               sdram_addr, sdram_writedata);
        end
        @(negedge clk);
        m1_write_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_burst_limit();
        int n0 = 0;
        int bad = 0;
        bit seen = 0;
        m0_write_n = 1'b0; m0_addr = 24'h50;
        m1_write_n = 1'b0; m1_addr = 24'h60;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (!m1_waitrequest) begin
                seen = 1;
                break;
            end
            if (!m0_waitrequest) n0++;
            @(negedge clk);
        end
        checks++;
        if (!seen || n0 != 16) begin
            errors++; $display("FAIL burst_count: got %0d m0 accepts (m1 granted=%0d) expected 16",
                               n0, seen);
        end
        if (m0_waitrequest !== 1'b1) bad++;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); #1;
            if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b0) bad++;
        end
        @(negedge clk);
        m1_write_n = 1'b1;
        #1;
        if (m0_waitrequest !== 1'b1) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL burst_m0_held: got %0d cycles with m0 not stalled, expected 0",
                               bad);
        end
        @(negedge clk); #1;
        checks++;
        if (m0_waitrequest !== 1'b0) begin
            errors++; $display("FAIL burst_m0_regrant: got wait=%b expected 0", m0_waitrequest);
        end
        @(negedge clk);
        m0_write_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_waitrequest_hold();
        int bad = 0;
        sdram_waitrequest = 1'b1;
        m1_read_n = 1'b0; m1_addr = 24'h123;
        m0_write_n = 1'b0; m0_addr = 24'h40;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            if (m1_waitrequest !== 1'b1 || sdram_addr !== 24'h123 || sdram_read_n !== 1'b0 ||
                m0_waitrequest !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0 || dut.pending_q !== 4'd0) begin
            errors++; $display("FAIL wait_hold: got %0d unstable cycles pending=%0d expected 0/0",
                               bad, dut.pending_q);
        end
        @(negedge clk);
        sdram_waitrequest = 1'b0;
        #1;
        checks++;
        if ({m1_waitrequest, sdram_read_n} !== 2'b00) begin
            errors++; $display("FAIL wait_release: got %b expected 00", {m1_waitrequest, sdram_read_n});
        end
        @(negedge clk);
        m1_read_n = 1'b1; m0_write_n = 1'b1;
        #1;
        checks++;
        if (dut.pending_q !== 4'd1) begin
            errors++; $display("FAIL wait_one_accept: got pending %0d expected 1", dut.pending_q);
        end
        @(negedge clk);
        sdram_readdatavalid = 1'b1; sdram_readdata = 16'h7777;
        #1;
        checks++;
        if ({m0_readdatavalid, m1_readdatavalid, m1_readdata} !== {2'b01, 16'h7777}) begin
            errors++; $display("FAIL wait_return: got valids %b data %h expected 01 7777",
                               {m0_readdatavalid, m1_readdatavalid}, m1_readdata);
        end
        @(negedge clk);
        sdram_readdatavalid = 1'b0;
        #1;
        checks++;
        if (dut.pending_q !== 4'd0) begin
            errors++; $display("FAIL wait_drain: got pending %0d expected 0", dut.pending_q);
        end
    endtask

    task automatic test_pipelined_reads();
        logic [15:0] exp_data [5];
        logic [1:0]  exp_vld  [5];
        int          due_q [$];
        logic [15:0] dat_q [$];
        logic [15:0] got_data;
        int i0 = 0;
        int i1 = 0;
        int got = 0;
        exp_data[0] = 16'h5A00; exp_data[1] = 16'h5A01; exp_data[2] = 16'h5A02;
        exp_data[3] = 16'h5A64; exp_data[4] = 16'h5A65;
        exp_vld[0] = 2'b10; exp_vld[1] = 2'b10; exp_vld[2] = 2'b10;
        exp_vld[3] = 2'b01; exp_vld[4] = 2'b01;
        for (int c = 0; c < 60 && got < 5; c++) begin
            @(negedge clk);
            if (due_q.size() > 0 && due_q[0] == c) begin
                sdram_readdatavalid = 1'b1;
                sdram_readdata = dat_q[0];
                void'(due_q.pop_front());
                void'(dat_q.pop_front());
            end else begin
                sdram_readdatavalid = 1'b0;
                sdram_readdata = '0;
            end
            m0_read_n = (i0 < 3) ? 1'b0 : 1'b1;
            m0_addr   = 24'(i0);
            m1_read_n = (i0 == 3 && i1 < 2) ? 1'b0 : 1'b1;
            m1_addr   = (i1 == 0) ? 24'd100 : 24'd101;
            #1;
            if (m0_readdatavalid || m1_readdatavalid) begin
                got_data = m1_readdatavalid ? m1_readdata : m0_readdata;
                checks++;
                if (got >= 5 || {m0_readdatavalid, m1_readdatavalid} !== exp_vld[got] ||
                    got_data !== exp_data[got]) begin
                    errors++;
                    $display("FAIL pipe_return_%0d: got valids %b data %h expected %b %h", got,
                             {m0_readdatavalid, m1_readdatavalid}, got_data,
                             (got < 5) ? exp_vld[got] : 2'b00, (got < 5) ? exp_data[got] : 16'h0);
                end
                got++;
            end
            // Controller model: fixed 3-cycle read latency, data derived from the address.
            if (!sdram_read_n && !sdram_waitrequest) begin
                due_q.push_back(c + 3);
                dat_q.push_back(sdram_addr[15:0] ^ 16'h5A00);
            end
            if (!m0_read_n && !m0_waitrequest) i0++;
            if (!m1_read_n && !m1_waitrequest) i1++;
        end
        @(negedge clk);
        sdram_readdatavalid = 1'b0;
        m0_read_n = 1'b1; m1_read_n = 1'b1;
        #1;
        checks++;
        if (got != 5 || dut.pending_q !== 4'd0) begin
            errors++; $display("FAIL pipe_total: got %0d returns pending %0d expected 5/0", got,
                               dut.pending_q);
        end
    endtask

    task automatic test_pending_full();
        int acc = 0;
        int bad = 0;
        for (int c = 0; c < 30 && acc < 8; c++) begin
            @(negedge clk);
            m0_read_n = 1'b0; m0_addr = 24'(acc);
            #1;
            if (!m0_waitrequest) acc++;
        end
        checks++;
        if (acc != 8) begin
            errors++; $display("FAIL full_fill: got %0d accepts expected 8", acc);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            m0_addr = 24'd8;
            #1;
            if ({m0_waitrequest, m1_waitrequest, sdram_read_n} !== 3'b111 ||
                dut.pending_q !== 4'd8) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL full_block: got %0d unblocked cycles expected 0", bad);
        end
        @(negedge clk);
        sdram_readdatavalid = 1'b1; sdram_readdata = 16'hAAAA;
        #1;
        checks++;
        if ({m0_readdatavalid, m1_readdatavalid, m0_readdata} !== {2'b10, 16'hAAAA}) begin
            errors++; $display("FAIL full_return: got %b %h expected 10 aaaa",
                               {m0_readdatavalid, m1_readdatavalid}, m0_readdata);
        end
        @(negedge clk);
        sdram_readdatavalid = 1'b0;
        #1;
        checks++;
        if ({m0_waitrequest, sdram_read_n, sdram_addr} !== {2'b00, 24'd8}) begin
            errors++; $display("FAIL full_ninth_accept: got wait=%b rd_n=%b addr=%h expected 0 0 8",
                               m0_waitrequest, sdram_read_n, sdram_addr);
        end
        @(negedge clk);
        m0_read_n = 1'b1;
        #1;
        checks++;
        if (dut.pending_q !== 4'd8) begin
            errors++; $display("FAIL full_refill: got pending %0d expected 8", dut.pending_q);
        end
        bad = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            sdram_readdatavalid = 1'b1;
            #1;
            if ({m0_readdatavalid, m1_readdatavalid} !== 2'b10) bad++;
        end
        @(negedge clk);
        sdram_readdatavalid = 1'b0;
        #1;
        checks++;
        if (bad != 0 || dut.pending_q !== 4'd4) begin
            errors++; $display("FAIL full_drain4: got %0d bad returns pending %0d expected 0/4", bad,
                               dut.pending_q);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if ({m0_waitrequest, m1_waitrequest, sdram_read_n, sdram_write_n} !== 4'b1111) begin
            errors++; $display("FAIL midreset_outputs: got %b expected 1111",
                               {m0_waitrequest, m1_waitrequest, sdram_read_n, sdram_write_n});
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (dut.pending_q !== 4'd0 || dut.rd_err_q !== 1'b0) begin
            errors++; $display("FAIL midreset_state: got pending %0d err %b expected 0 0",
                               dut.pending_q, dut.rd_err_q);
        end
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            sdram_readdatavalid = 1'b1; sdram_readdata = 16'h5555;
            #1;
            if ({m0_readdatavalid, m1_readdatavalid} !== 2'b00) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL stray_dropped: got %0d forwarded returns expected 0", bad);
        end
        @(negedge clk);
        sdram_readdatavalid = 1'b0;
        #1;
        checks++;
        if (dut.rd_err_q !== 1'b1) begin
            errors++; $display("FAIL stray_error_flag: got %b expected 1", dut.rd_err_q);
        end
    endtask

    initial begin
        test_reset();
        test_tie();
        test_burst_limit();
        test_waitrequest_hold();
        test_pipelined_reads();
        test_pending_full();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
